truth_table_sweeper: RTL and testbench

Self-checking sweep controller for the Lab 3 4-input/2-output combinational datapath (inputs a, b, c, d; outputs f, g). On `start` it drives all 16 input combinations in ascending order and waits a programmable settle time per vector. It then samples f and g into 16-bit truth-table maps and compares them against expected maps, reporting pass/fail, error count and the first failing index. It sits between a start/status source (bench or board switches/LEDs) and the combinational block under control.

---
 rtl/truth_table_sweeper.sv | 138 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Sweep controller for a 4-input/2-output combinational block. On start it
// drives the 16 input combinations {a,b,c,d} = 0..15 in ascending order. Each
// vector is held for SETTLE_CYCLES cycles and then f_in/g_in are captured into
// 16-bit truth-table maps. The captured maps are checked against EXP_F/EXP_G,
// and the error count and first failing index are reported.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           level-sampled start request (honoured in IDLE and DONE)
//   abort           returns to IDLE from any state; partial results are kept
//   f_in, g_in      outputs of the block under test
//   a, b, c, d      inputs to the block under test ({a,b,c,d} = idx, a is MSB)
//   busy            high in SETTLE and SAMPLE
//   done            high in DONE
//   pass            done with no mismatches
//   f_map, g_map    captured truth tables (bit i = output for index i)
//   err_count       number of mismatching indices (0..16)
//   first_err_idx   lowest mismatching index, meaningful when err_count != 0
//   state_dbg       current FSM state, for checkers
//
// Handshake: start is a plain level. It is acted on at a rising edge only
// when the FSM is in IDLE or DONE and abort is low. abort is acted on at any
// rising edge outside IDLE and wins over start.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXP_F         = 16'h6996,
  parameter logic [15:0] EXP_G         = 16'h8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  input  logic        g_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] f_map,
  output logic [15:0] g_map,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Last settle count before moving to SAMPLE. SETTLE therefore occupies
  // exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic       mismatch;

  // A single mismatch per index, even when both f and g differ.
  assign mismatch = (f_in != EXP_F[idx]) || (g_in != EXP_G[idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= 4'd0;
      cnt           <= 4'd0;
      f_map         <= 16'h0;
      g_map         <= 16'h0;
      err_count     <= 5'd0;
      first_err_idx <= 4'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (state == ST_DONE && abort) begin
            state <= ST_IDLE;
          end else if (start) begin
            state         <= ST_SETTLE;
            idx           <= 4'd0;
            cnt           <= 4'd0;
            f_map         <= 16'h0;
            g_map         <= 16'h0;
            err_count     <= 5'd0;
            first_err_idx <= 4'd0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == SETTLE_LAST) begin
              state <= ST_SAMPLE;
            end
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            f_map[idx] <= f_in;
            g_map[idx] <= g_in;
            if (mismatch) begin
              err_count <= err_count + 5'd1;
              if (err_count == 5'd0) begin
                first_err_idx <= idx;
              end
            end
            // idx never wraps: the last index always finishes the sweep.
            if (idx == 4'd15) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + 4'd1;
              cnt   <= 4'd0;
              state <= ST_SETTLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status and drive outputs are decoded from registered state only, so
  // a..d change on the edge that enters SETTLE for each index.
  assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == 5'd0);

  assign {a, b, c, d} = busy ? idx : 4'd0;

  assign state_dbg = state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a behavioural model of the
// combinational block (f = a^b^c^d, g = a&b&c&d) plus fault-injection modes.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        f_in;
  logic        g_in;
  logic        a, b, c, d;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] f_map;
  logic [15:0] g_map;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int vec_errs = 0;
  int mode = 0;  // 0 clean, 1 invert f at index 5, 2 g stuck at 1

  truth_table_sweeper dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .f_in          (f_in),
    .g_in          (g_in),
    .a             (a),
    .b             (b),
    .c             (c),
    .d             (d),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .f_map         (f_map),
    .g_map         (g_map),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- block under control ----------------
  always_comb begin
    f_in = a ^ b ^ c ^ d;
    g_in = a & b & c & d;
    if (mode == 1 && {a, b, c, d} == 4'd5) f_in = ~f_in;
    if (mode == 2) g_in = 1'b1;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulse start for one cycle, then follow the sweep until done. a..d and
  // busy are checked every cycle against the 3-cycles-per-vector schedule.
  // restart_at >= 1 re-pulses start that many cycles after the start edge.
  task automatic run_sweep(input int restart_at, output int cycles, output logic [15:0] map_at_start);
    logic [3:0] exp_vec;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 0;
    map_at_start = f_map;
    if ({a, b, c, d} !== 4'd0 || busy !== 1'b1) vec_errs++;
    while (!done && cycles < 200) begin
      start = (cycles + 1 == restart_at);
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
      exp_vec = (cycles < 48) ? 4'(cycles / 3) : 4'd0;
      if ({a, b, c, d} !== exp_vec || busy !== (cycles < 48)) vec_errs++;
    end
  endtask

  // Wait until the drive vector equals v (bounded).
  task automatic wait_vec(input logic [3:0] v, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if ({a, b, c, d} == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  int          cyc;
  logic [15:0] m0;
  logic        ok;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #12;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_pass", pass, 0);
    check_eq("reset_vec", {a, b, c, d}, 0);
    check_eq("reset_fmap", f_map, 16'h0);
    check_eq("reset_err", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_no_start", busy, 0);

    // 1: clean sweep
    mode = 0;
    vec_errs = 0;
    run_sweep(-1, cyc, m0);
    check_eq("clean_latency", cyc, 48);
    check_eq("clean_fmap", f_map, 16'h6996);
    check_eq("clean_gmap", g_map, 16'h8000);
    check_eq("clean_err", err_count, 0);
    check_eq("clean_pass", pass, 1);
    check_eq("clean_vec_sched", vec_errs, 0);

    // 2: restart from DONE with f inverted at index 5
    mode = 1;
    vec_errs = 0;
    run_sweep(-1, cyc, m0);
    check_eq("restart_clears_fmap", m0, 16'h0);
    check_eq("inj_latency", cyc, 48);
    check_eq("inj_fmap", f_map, 16'h69B6);
    check_eq("inj_gmap", g_map, 16'h8000);
    check_eq("inj_err", err_count, 1);
    check_eq("inj_first", first_err_idx, 5);
    check_eq("inj_pass", pass, 0);
    check_eq("inj_done", done, 1);

    // 3: g stuck at 1, with a start re-pulse mid-sweep that must be ignored
    mode = 2;
    vec_errs = 0;
    run_sweep(10, cyc, m0);
    check_eq("g1_latency", cyc, 48);
    check_eq("g1_vec_sched", vec_errs, 0);
    check_eq("g1_gmap", g_map, 16'hFFFF);
    check_eq("g1_fmap", f_map, 16'h6996);
    check_eq("g1_err", err_count, 15);
    check_eq("g1_first", first_err_idx, 0);
    check_eq("g1_pass", pass, 0);

    // 4: abort and start together in DONE -> abort wins
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check_eq("abort_pri_done", done, 0);
    check_eq("abort_pri_busy", busy, 0);
    check_eq("abort_pri_err_kept", err_count, 15);

    // 5: abort while idx == 7
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec(4'd7, ok);
    check_eq("abort_reach_idx7", ok, 1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_vec", {a, b, c, d}, 0);
    check_eq("abort_fmap", f_map, 16'h0016);
    check_eq("abort_gmap", g_map, 16'h0000);
    repeat (3) @(negedge clk);
    check_eq("abort_stays_idle", busy, 0);

    // 6: asynchronous reset mid-SETTLE at idx 3
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec(4'd3, ok);
    check_eq("rst_reach_idx3", ok, 1);
    check_eq("rst_pre_fmap", f_map, 16'h0006);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_vec", {a, b, c, d}, 0);
    check_eq("arst_fmap", f_map, 16'h0);
    check_eq("arst_err", err_count, 0);
    check_eq("arst_state", state_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("arst_no_done", done, 0);

    vec_errs = 0;
    run_sweep(-1, cyc, m0);
    check_eq("post_rst_latency", cyc, 48);
    check_eq("post_rst_fmap", f_map, 16'h6996);
    check_eq("post_rst_pass", pass, 1);
    check_eq("post_rst_vec_sched", vec_errs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
